// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Forwarding and load-use interlock unit for the DLX pipeline.
//   A DEPTH-entry shift register records the destination of every in-flight
//   instruction (entry 0 = EX, 1 = MEM, 2 = WB for the default depth).
//   Each ID operand is resolved against the youngest matching in-flight
//   writer. If there is no match, the register-file value is used. A matching
//   load whose data is not yet on stage_result raises a stall.
//   A saturating counter records how many cycles were stalled.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   issue_valid/we/is_load         attributes of the instruction in ID
//   issue_rd, issue_rs1, issue_rs2 destination and source register numbers
//   flush                          ID instruction is killed; it enters as a bubble
//   rf_rs1, rf_rs2                 register-file read data (write-then-read)
//   stage_result                   stage k result at [k*DATA_W +: DATA_W]
//   rs1_value, rs2_value           resolved operands
//   rs1_fwd, rs2_fwd               operand taken from stage_result
//   stall                          hold PC and IF/ID; a bubble goes to ID/EX
//   stall_count                    saturating count of stall cycles
module hazard_scoreboard #(
  parameter int DATA_W           = 32,
  parameter int REG_AW           = 5,
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 1,
  parameter int CNT_W            = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic                    issue_we,
  input  logic                    issue_is_load,
  input  logic [REG_AW-1:0]       issue_rd,
  input  logic [REG_AW-1:0]       issue_rs1,
  input  logic [REG_AW-1:0]       issue_rs2,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       rf_rs1,
  input  logic [DATA_W-1:0]       rf_rs2,
  input  logic [DEPTH*DATA_W-1:0] stage_result,
  output logic [DATA_W-1:0]       rs1_value,
  output logic [DATA_W-1:0]       rs2_value,
  output logic                    rs1_fwd,
  output logic                    rs2_fwd,
  output logic                    stall,
  output logic [CNT_W-1:0]        stall_count
);

  typedef struct packed {
    logic              hazard;
    logic              fwd;
    logic [DATA_W-1:0] value;
  } lookup_t;

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_we;
  logic [DEPTH-1:0]  ent_load;
  logic [REG_AW-1:0] ent_rd [DEPTH];

  lookup_t look_rs1;
  lookup_t look_rs2;
  logic    accept;

  // The scan runs youngest first. The first match ends the search, so an
  // older writer of the same register is ignored, even when the younger
  // match is a load that is not yet ready.
  function automatic lookup_t resolve(input logic [REG_AW-1:0] rs,
                                      input logic [DATA_W-1:0] rf_val);
    lookup_t r;
    logic    found;
    r     = '{hazard: 1'b0, fwd: 1'b0, value: rf_val};
    found = 1'b0;
    if (rs == '0) begin
      r.value = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && ent_valid[k] && ent_we[k] && (ent_rd[k] == rs)) begin
          found = 1'b1;
          if (ent_load[k] && (k < LOAD_READY_STAGE)) begin
            r.hazard = 1'b1;
          end else begin
            r.fwd   = 1'b1;
            r.value = stage_result[k*DATA_W +: DATA_W];
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    look_rs1 = resolve(issue_rs1, rf_rs1);
    look_rs2 = resolve(issue_rs2, rf_rs2);
  end

  assign rs1_value = look_rs1.value;
  assign rs2_value = look_rs2.value;
  assign rs1_fwd   = look_rs1.fwd;
  assign rs2_fwd   = look_rs2.fwd;

  // flush masks stall: a killed instruction never holds the front end.
  assign stall  = issue_valid & ~flush & (look_rs1.hazard | look_rs2.hazard);
  assign accept = issue_valid & ~flush & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid   <= '0;
      ent_we      <= '0;
      ent_load    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ent_rd[k] <= '0;
      end
      stall_count <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_we[k]    <= ent_we[k-1];
        ent_load[k]  <= ent_load[k-1];
        ent_rd[k]    <= ent_rd[k-1];
      end
      if (accept) begin
        ent_valid[0] <= 1'b1;
        ent_we[0]    <= issue_we;
        ent_load[0]  <= issue_is_load;
        ent_rd[0]    <= issue_rd;
      end else begin
        ent_valid[0] <= 1'b0;
        ent_we[0]    <= 1'b0;
        ent_load[0]  <= 1'b0;
        ent_rd[0]    <= '0;
      end
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule
